// File: rtl/comm_pkg.sv
// comm_pkg: shared definitions for the DSP-to-DAC bridge.
//   - DSP address map constants (write window base, read-back addresses)
//   - DAC write FSM state encoding
//   - status word bit positions and default parameter values
//   - helper that decodes the DAC write window
package comm_pkg;

  // DSP address map
  localparam logic [17:0] WR_BASE   = 18'h00000;
  localparam int          WR_BITS   = 5;
  localparam logic [17:0] RD_LAST   = 18'h00100;
  localparam logic [17:0] RD_COUNT  = 18'h00200;
  localparam logic [17:0] RD_STATUS = 18'h00300;

  // Default build parameters
  localparam int          DAC_WR_CYCLES_DEF = 2;
  localparam logic [7:0]  STATUS_ID_DEF     = 8'h5A;

  // Status word layout
  localparam int STAT_BUSY_BIT = 15;
  localparam int STAT_DROP_BIT = 14;

  typedef enum logic [1:0] {
    DAC_IDLE,
    DAC_SETUP,
    DAC_STROBE,
    DAC_HOLD
  } dac_state_e;

  // True when the address falls inside the 32-entry DAC write window.
  function automatic logic in_wr_window(input logic [17:0] a);
    return (a[17:WR_BITS] == WR_BASE[17:WR_BITS]);
  endfunction

endpackage

// File: rtl/comm_dac_wr.sv
// comm_dac_wr: parallel-DAC write cycle generator.
// A load pulse while idle runs one cycle: SETUP (1 clk), STROBE
// (DAC_WR_CYCLES clks with cs_n low), HOLD (1 clk), back to IDLE.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   load                start a cycle (ignored unless idle)
//   load_add/load_data  DAC address/data captured on load
//   busy                high whenever the FSM is not idle
//   dac_cs_n, dac_re_wr DAC strobes (registered)
//   dac_add, dac_data   DAC address/data, held after the cycle ends
module comm_dac_wr
  import comm_pkg::*;
#(
  parameter int DAC_WR_CYCLES = DAC_WR_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [4:0]  load_add,
  input  logic [15:0] load_data,
  output logic        busy,
  output logic        dac_cs_n,
  output logic        dac_re_wr,
  output logic [4:0]  dac_add,
  output logic [15:0] dac_data
);

  localparam int CNT_W = (DAC_WR_CYCLES > 1) ? $clog2(DAC_WR_CYCLES) : 1;

  dac_state_e       state;
  logic [CNT_W-1:0] strobe_cnt;

  assign busy = (state != DAC_IDLE);

  // Strobes are set on the transition into each state so every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= DAC_IDLE;
      strobe_cnt <= '0;
      dac_cs_n   <= 1'b1;
      dac_re_wr  <= 1'b1;
      dac_add    <= '0;
      dac_data   <= '0;
    end else begin
      case (state)
        DAC_IDLE: begin
          if (load) begin
            state     <= DAC_SETUP;
            dac_add   <= load_add;
            dac_data  <= load_data;
            dac_re_wr <= 1'b0;
          end
        end
        DAC_SETUP: begin
          state      <= DAC_STROBE;
          strobe_cnt <= '0;
          dac_cs_n   <= 1'b0;
        end
        DAC_STROBE: begin
          if (strobe_cnt == CNT_W'(DAC_WR_CYCLES - 1)) begin
            state    <= DAC_HOLD;
            dac_cs_n <= 1'b1;
          end else begin
            strobe_cnt <= strobe_cnt + 1'b1;
          end
        end
        DAC_HOLD: begin
          state     <= DAC_IDLE;
          dac_re_wr <= 1'b1;
        end
        default: begin
          state     <= DAC_IDLE;
          dac_cs_n  <= 1'b1;
          dac_re_wr <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/communication.sv
// communication: DSP external-memory bus to parallel-DAC bridge.
// DSP writes into 0x00000-0x0001F become single DAC write cycles; a small
// read-back window returns last DAC data (0x00100), write count (0x00200)
// and status (0x00300). Reads elsewhere return 0x0000.
// Optional: define COMM_WR_COUNT_EN to build the 16-bit write counter;
// without it 0x00200 reads 0x0000.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   rd_n, wr_n          DSP strobes (active low, asynchronous)
//   addr                DSP address
//   data                DSP data bus, driven only during decoded reads
//   dac_re_wr, dac_cs_n DAC select/strobe
//   dac_add, dac_data   DAC address and parallel data
module communication
  import comm_pkg::*;
#(
  parameter int         DAC_WR_CYCLES = DAC_WR_CYCLES_DEF,
  parameter logic [7:0] STATUS_ID     = STATUS_ID_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [17:0] addr,
  inout  wire  [15:0] data,
  output logic        dac_re_wr,
  output logic        dac_cs_n,
  output logic [4:0]  dac_add,
  output logic [15:0] dac_data
);

  logic        wr_s1, wr_s2;
  logic [17:0] addr_s1;
  logic [15:0] data_s1;
  logic        cap_pending;
  logic [4:0]  cap_add;
  logic [15:0] cap_data;
  logic [15:0] last_data;
  logic        drop_flag;
  logic        busy;
  logic        commit;
  logic        load;
  logic [15:0] status_word;
  logic [15:0] rd_value;

  // Bus sampling; wr_n idles high so reset leaves no false rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_s1   <= 1'b1;
      wr_s2   <= 1'b1;
      addr_s1 <= '0;
      data_s1 <= '0;
    end else begin
      wr_s1   <= wr_n;
      wr_s2   <= wr_s1;
      addr_s1 <= addr;
      data_s1 <= data;
    end
  end

  // A write commits on the rising edge of the sampled strobe.
  assign commit = wr_s1 && !wr_s2 && cap_pending;
  assign load   = commit && !busy;

  // Capture repeats every clock of the strobe, so the final sample is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_pending <= 1'b0;
      cap_add     <= '0;
      cap_data    <= '0;
    end else if (!wr_s1 && in_wr_window(addr_s1)) begin
      cap_pending <= 1'b1;
      cap_add     <= addr_s1[4:0];
      cap_data    <= data_s1;
    end else if (commit) begin
      cap_pending <= 1'b0;
    end
  end

  // Drop flag is sticky: only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_data <= '0;
      drop_flag <= 1'b0;
    end else if (load) begin
      last_data <= cap_data;
    end else if (commit) begin
      drop_flag <= 1'b1;
    end
  end

`ifdef COMM_WR_COUNT_EN
  logic [15:0] wr_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= '0;
    end else if (load) begin
      wr_count <= wr_count + 16'd1;
    end
  end
`endif

  comm_dac_wr #(
    .DAC_WR_CYCLES(DAC_WR_CYCLES)
  ) u_dac_wr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_add (cap_add),
    .load_data(cap_data),
    .busy     (busy),
    .dac_cs_n (dac_cs_n),
    .dac_re_wr(dac_re_wr),
    .dac_add  (dac_add),
    .dac_data (dac_data)
  );

  always_comb begin
    status_word                = '0;
    status_word[STAT_BUSY_BIT] = busy;
    status_word[STAT_DROP_BIT] = drop_flag;
    status_word[7:0]           = STATUS_ID;
  end

  // Read mux decodes the raw pins so read data has no clock latency.
  always_comb begin
    rd_value = '0;
    case (addr)
      RD_LAST:   rd_value = last_data;
`ifdef COMM_WR_COUNT_EN
      RD_COUNT:  rd_value = wr_count;
`else
      RD_COUNT:  rd_value = '0;
`endif
      RD_STATUS: rd_value = status_word;
      default:   rd_value = '0;
    endcase
  end

  // A simultaneous write strobe keeps the bus released.
  assign data = (!rd_n && wr_n) ? rd_value : 16'hzzzz;

endmodule

// File: tb/tb_communication.sv
// tb_communication: self-checking bench for the communication bridge.
// Table vectors cover the main write/read flow, hand sequences cover busy
// status, simultaneous strobes, dropped writes and reset mid-strobe, then
// random writes/reads are checked against a behavioural model.
module tb_communication;

  localparam int DAC_WR_CYCLES = 2;
`ifdef COMM_WR_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic [17:0] addr = '0;
  logic [15:0] dspData = '0;
  logic        dspDrive = 1'b0;
  wire  [15:0] data;
  logic        dac_re_wr, dac_cs_n;
  logic [4:0]  dac_add;
  logic [15:0] dac_data;

  assign data = dspDrive ? dspData : 16'hzzzz;

  communication #(
    .DAC_WR_CYCLES(DAC_WR_CYCLES),
    .STATUS_ID    (8'h5A)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_n     (rd_n),
    .wr_n     (wr_n),
    .addr     (addr),
    .data     (data),
    .dac_re_wr(dac_re_wr),
    .dac_cs_n (dac_cs_n),
    .dac_add  (dac_add),
    .dac_data (dac_data)
  );

  initial forever #50 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [4:0]  add;
    logic [15:0] data;
    int          reLen;
    int          csLen;
  } dac_cycle_t;

  typedef struct {
    logic [4:0]  add;
    logic [15:0] data;
  } dac_exp_t;

  typedef struct {
    bit          isWrite;
    logic [17:0] addr;
    logic [15:0] wdata;
    bit          expCycle;
    logic [4:0]  expAdd;
    logic [15:0] expData;
    logic [15:0] expRead;
  } vec_t;

  dac_cycle_t seenQ[$];
  dac_exp_t   expQ[$];
  vec_t       tbl[16];
  int         strayCs = 0;

  // Behavioural model state
  logic [15:0] mLast;
  logic [15:0] mData;
  logic [4:0]  mAdd;
  int          mCount;
  bit          mDrop;

  // Monitor: one record per DAC cycle, measured as lengths of the low pulses.
  initial begin
    int reLen;
    int csLen;
    logic [4:0]  monAdd;
    logic [15:0] monData;
    reLen = 0;
    csLen = 0;
    monAdd = '0;
    monData = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        reLen = 0;
        csLen = 0;
      end else if (!dac_re_wr) begin
        reLen++;
        if (!dac_cs_n) begin
          csLen++;
          monAdd = dac_add;
          monData = dac_data;
        end
      end else begin
        if (!dac_cs_n) strayCs++;
        if (reLen != 0) begin
          dac_cycle_t c;
          c.add = monAdd;
          c.data = monData;
          c.reLen = reLen;
          c.csLen = csLen;
          seenQ.push_back(c);
          reLen = 0;
          csLen = 0;
        end
      end
    end
  end

  function automatic logic [15:0] expCount(input int n);
    return COUNT_EN ? 16'(n) : 16'h0000;
  endfunction

  function automatic logic [15:0] modelRead(input logic [17:0] a);
    if (a == 18'h00100) return mLast;
    if (a == 18'h00200) return expCount(mCount);
    if (a == 18'h00300) return {1'b0, mDrop, 6'b0, 8'h5A};
    return 16'h0000;
  endfunction

  task automatic modelReset();
    mLast = '0;
    mData = '0;
    mAdd = '0;
    mCount = 0;
    mDrop = 1'b0;
    seenQ.delete();
    expQ.delete();
  endtask

  // Accepted write: only the 32-word window at address 0 reaches the DAC.
  task automatic modelWrite(input logic [17:0] a, input logic [15:0] d);
    dac_exp_t e;
    if (a < 18'h00020) begin
      e.add = a[4:0];
      e.data = d;
      expQ.push_back(e);
      mLast = d;
      mCount = (mCount + 1) % 65536;
      mAdd = a[4:0];
      mData = d;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic dspWrite(input logic [17:0] a, input logic [15:0] d);
    addr = a;
    dspData = d;
    dspDrive = 1'b1;
    #40 wr_n = 1'b0;
    #160 wr_n = 1'b1;
    #80 dspDrive = 1'b0;
  endtask

  task automatic dspRead(input logic [17:0] a, output logic [15:0] v);
    addr = a;
    #40 rd_n = 1'b0;
    #40 v = data;
    #20 rd_n = 1'b1;
    #20;
  endtask

  task automatic checkDacCycles(input string name);
    checkOutput({name, " cycles"}, 32'(seenQ.size()), 32'(expQ.size()));
    while (seenQ.size() > 0 && expQ.size() > 0) begin
      dac_cycle_t s;
      dac_exp_t   e;
      s = seenQ.pop_front();
      e = expQ.pop_front();
      checkOutput({name, " add"}, 32'(s.add), 32'(e.add));
      checkOutput({name, " data"}, 32'(s.data), 32'(e.data));
      checkOutput({name, " re_wr len"}, 32'(s.reLen), 32'(DAC_WR_CYCLES + 2));
      checkOutput({name, " cs len"}, 32'(s.csLen), 32'(DAC_WR_CYCLES));
    end
    checkOutput({name, " stray cs"}, 32'(strayCs), 32'd0);
    seenQ.delete();
    expQ.delete();
    strayCs = 0;
  endtask

  task automatic checkIdle(input string name);
    checkOutput({name, " cs_n"}, 32'(dac_cs_n), 32'd1);
    checkOutput({name, " re_wr"}, 32'(dac_re_wr), 32'd1);
    checkOutput({name, " dac_add"}, 32'(dac_add), 32'(mAdd));
    checkOutput({name, " dac_data"}, 32'(dac_data), 32'(mData));
  endtask

  // Bench holds 0 on the bus; any DUT drive of the status word shows up.
  task automatic checkNoDrive(input string name);
    addr = 18'h00300;
    dspData = 16'h0000;
    dspDrive = 1'b1;
    #30 checkOutput(name, 32'(data), 32'd0);
    dspDrive = 1'b0;
    #10;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [15:0] rv;
    dac_exp_t    e;
    if (v.isWrite) begin
      dspWrite(v.addr, v.wdata);
      if (v.expCycle) begin
        e.add = v.expAdd;
        e.data = v.expData;
        expQ.push_back(e);
        mLast = v.expData;
        mCount++;
        mAdd = v.expAdd;
        mData = v.expData;
      end
      #2100;
      checkDacCycles($sformatf("vec%0d", idx));
      checkIdle($sformatf("vec%0d idle", idx));
    end else begin
      dspRead(v.addr, rv);
      checkOutput($sformatf("vec%0d read 0x%05h", idx, v.addr), 32'(rv), 32'(v.expRead));
    end
  endtask

  initial begin
    logic [15:0] rv;
    logic [17:0] ra;
    logic [15:0] rd;

    modelReset();

    // Reset state
    #230;
    checkIdle("reset");
    checkNoDrive("reset bus");
    rst_n = 1'b1;
    #100;

    tbl[0]  = '{1'b1, 18'h00000, 16'h0010, 1'b1, 5'd0,  16'h0010, 16'h0000};
    tbl[1]  = '{1'b0, 18'h00100, 16'h0000, 1'b0, 5'd0,  16'h0000, 16'h0010};
    tbl[2]  = '{1'b0, 18'h00200, 16'h0000, 1'b0, 5'd0,  16'h0000, expCount(1)};
    tbl[3]  = '{1'b0, 18'h00300, 16'h0000, 1'b0, 5'd0,  16'h0000, 16'h005A};
    tbl[4]  = '{1'b1, 18'h00000, 16'h0020, 1'b1, 5'd0,  16'h0020, 16'h0000};
    tbl[5]  = '{1'b0, 18'h00200, 16'h0000, 1'b0, 5'd0,  16'h0000, expCount(2)};
    tbl[6]  = '{1'b1, 18'h00000, 16'h0030, 1'b1, 5'd0,  16'h0030, 16'h0000};
    tbl[7]  = '{1'b0, 18'h00200, 16'h0000, 1'b0, 5'd0,  16'h0000, expCount(3)};
    tbl[8]  = '{1'b1, 18'h00005, 16'h1234, 1'b1, 5'd5,  16'h1234, 16'h0000};
    tbl[9]  = '{1'b1, 18'h00040, 16'hBEEF, 1'b0, 5'd0,  16'h0000, 16'h0000};
    tbl[10] = '{1'b0, 18'h00150, 16'h0000, 1'b0, 5'd0,  16'h0000, 16'h0000};
    tbl[11] = '{1'b0, 18'h00100, 16'h0000, 1'b0, 5'd0,  16'h0000, 16'h1234};
    tbl[12] = '{1'b0, 18'h00300, 16'h0000, 1'b0, 5'd0,  16'h0000, 16'h005A};
    tbl[13] = '{1'b1, 18'h0001F, 16'hFFFF, 1'b1, 5'd31, 16'hFFFF, 16'h0000};
    tbl[14] = '{1'b1, 18'h00020, 16'h5555, 1'b0, 5'd0,  16'h0000, 16'h0000};
    tbl[15] = '{1'b0, 18'h00100, 16'h0000, 1'b0, 5'd0,  16'h0000, 16'hFFFF};

    for (int i = 0; i < 16; i++) applyStimulus(tbl[i], i);

    // Busy bit visible while a DAC cycle runs
    dspWrite(18'h00003, 16'hABCD);
    modelWrite(18'h00003, 16'hABCD);
    for (int i = 0; i < 20 && dac_re_wr; i++) @(negedge clk);
    checkOutput("busy wait re_wr", 32'(dac_re_wr), 32'd0);
    dspRead(18'h00300, rv);
    checkOutput("status busy", 32'(rv), 32'h805A);
    #2100;
    checkDacCycles("busy write");

    // Simultaneous strobes: bus stays released
    addr = 18'h00300;
    dspData = 16'h0000;
    dspDrive = 1'b1;
    #40 rd_n = 1'b0;
    wr_n = 1'b0;
    #80 checkOutput("rd+wr no drive", 32'(data), 32'd0);
    #80 wr_n = 1'b1;
    rd_n = 1'b1;
    #80 dspDrive = 1'b0;
    #2100;
    checkDacCycles("rd+wr status");

    // Simultaneous strobes in the write window: write still captured
    addr = 18'h00007;
    dspData = 16'h0707;
    dspDrive = 1'b1;
    #40 rd_n = 1'b0;
    wr_n = 1'b0;
    #160 wr_n = 1'b1;
    rd_n = 1'b1;
    #80 dspDrive = 1'b0;
    modelWrite(18'h00007, 16'h0707);
    #2100;
    checkDacCycles("rd+wr capture");
    checkIdle("rd+wr idle");

    // Back-to-back writes: second lands while busy and is dropped
    dspWrite(18'h00001, 16'h1111);
    dspWrite(18'h00002, 16'h2222);
    modelWrite(18'h00001, 16'h1111);
    mDrop = 1'b1;
    #2100;
    checkDacCycles("drop");
    checkIdle("drop idle");
    dspRead(18'h00300, rv);
    checkOutput("status drop", 32'(rv), 32'h405A);
    dspRead(18'h00100, rv);
    checkOutput("last after drop", 32'(rv), 32'h1111);
    dspRead(18'h00200, rv);
    checkOutput("count after drop", 32'(rv), 32'(expCount(mCount)));

    // Randomized writes and reads against the model
    for (int i = 0; i < 24; i++) begin
      int op;
      op = $urandom_range(2, 0);
      if (op != 2) begin
        if ($urandom_range(3, 0) != 0) ra = 18'($urandom_range(31, 0));
        else ra = 18'h00020 + 18'($urandom_range(262111, 0));
        rd = 16'($urandom);
        dspWrite(ra, rd);
        modelWrite(ra, rd);
        #2100;
        checkDacCycles($sformatf("rand%0d", i));
        checkIdle($sformatf("rand%0d idle", i));
      end else begin
        case ($urandom_range(3, 0))
          0: ra = 18'h00100;
          1: ra = 18'h00200;
          2: ra = 18'h00300;
          default: ra = 18'($urandom);
        endcase
        dspRead(ra, rv);
        checkOutput($sformatf("rand%0d read 0x%05h", i, ra), 32'(rv), 32'(modelRead(ra)));
      end
    end

    // Reset asserted during STROBE aborts the cycle at once
    dspWrite(18'h00004, 16'h4444);
    for (int i = 0; i < 20 && dac_cs_n; i++) @(negedge clk);
    checkOutput("strobe wait cs_n", 32'(dac_cs_n), 32'd0);
    #10 rst_n = 1'b0;
    #1;
    modelReset();
    checkIdle("reset mid-strobe");
    #100 rst_n = 1'b1;
    #100;
    seenQ.delete();
    strayCs = 0;
    dspRead(18'h00200, rv);
    checkOutput("count after reset", 32'(rv), 32'(expCount(0)));
    dspRead(18'h00300, rv);
    checkOutput("status after reset", 32'(rv), 32'h005A);
    dspRead(18'h00100, rv);
    checkOutput("last after reset", 32'(rv), 32'h0000);
    #1000;
    checkDacCycles("post reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
